// File: rtl/gtfraw_vnc_rx_sof_det_if.sv
// Bus bundle for the GTF raw-mode RX start-of-frame detector.
// The master side drives raw data and controls; the slave side (the detector)
// returns the SOF pulse, capture fields, statistics and FSM state.
interface gtfraw_vnc_rx_sof_det_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32,
  parameter int CNT_W  = 16
);
  localparam int BP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] gtf_ch_rxrawdata;
  logic              sync_error;
  logic              ctl_en;
  logic              ctl_trig_src;
  logic              ctl_continuous;
  logic [15:0]       ctl_holdoff;
  logic              ctl_cnt_clr;

  logic              rx_sof;
  logic [BP_W-1:0]   rx_sof_bitpos;
  logic [TS_W-1:0]   rx_sof_ts;
  logic              rx_start_measured_run;
  logic [CNT_W-1:0]  stat_sof_cnt;
  logic [1:0]        stat_state;

  modport master (
    output gtf_ch_rxrawdata, sync_error, ctl_en, ctl_trig_src,
           ctl_continuous, ctl_holdoff, ctl_cnt_clr,
    input  rx_sof, rx_sof_bitpos, rx_sof_ts, rx_start_measured_run,
           stat_sof_cnt, stat_state
  );

  modport slave (
    input  gtf_ch_rxrawdata, sync_error, ctl_en, ctl_trig_src,
           ctl_continuous, ctl_holdoff, ctl_cnt_clr,
    output rx_sof, rx_sof_bitpos, rx_sof_ts, rx_start_measured_run,
           stat_sof_cnt, stat_state
  );
endinterface

// File: rtl/gtfraw_vnc_rx_sof_det.sv
// RX start-of-frame detector for the GTF raw-mode latency path.
// Looks for a one-hot word preceded by PRE_ZERO all-zero words (or takes the
// external sync_error strobe), and emits a registered SOF pulse together with
// the hot-bit position, a timestamp and a saturating event count.
// One-shot and continuous (holdoff-spaced) re-arming are supported.
module gtfraw_vnc_rx_sof_det #(
  parameter int DATA_W   = 16,
  parameter int PRE_ZERO = 1,
  parameter int TS_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic                          rx_clk,
  input  logic                          rx_rst_n,
  gtfraw_vnc_rx_sof_det_if.slave        bus
);
  localparam int         BP_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [7:0] PZ   = 8'(PRE_ZERO);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_hcnt;
  logic [15:0]       w_hcnt_nxt;
  logic              r_first;
  logic [7:0]        r_zero_run;
  logic [TS_W-1:0]   r_ts;
  logic [CNT_W-1:0]  r_cnt;

  logic              r_vld_p1;
  logic [BP_W-1:0]   r_bitpos_p1;
  logic [TS_W-1:0]   r_ts_p1;
  logic              r_run_p1;

  logic [DATA_W-1:0] w_data;
  logic              w_onehot;
  logic              w_pat_trig;
  logic              w_trig;
  logic              w_fire;
  logic [BP_W-1:0]   w_bitpos;

  // True when exactly one bit of the word is set.
  function automatic logic f_is_onehot(input logic [DATA_W-1:0] d);
    return (d != '0) && ((d & (d - DATA_W'(1))) == '0);
  endfunction

  // Index of the highest set bit; for a one-hot word this is the hot bit.
  function automatic logic [BP_W-1:0] f_hot_index(input logic [DATA_W-1:0] d);
    logic [BP_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) idx = BP_W'(i);
    end
    return idx;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign w_data     = bus.gtf_ch_rxrawdata;
  assign w_onehot   = f_is_onehot(w_data);
  // zero_run is the pre-update value: the zeros must precede the marker word.
  assign w_pat_trig = w_onehot && (r_zero_run == PZ);
  assign w_trig     = bus.ctl_trig_src ? bus.sync_error : w_pat_trig;
  assign w_bitpos   = bus.ctl_trig_src ? '0 : f_hot_index(w_data);

  // Next-state logic; dropping ctl_en overrides everything, including a trig.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_fire      = 1'b0;
    if (!bus.ctl_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (w_trig) begin
            w_fire = 1'b1;
            if (!bus.ctl_continuous) begin
              w_state_nxt = S_DONE;
            end else if (bus.ctl_holdoff == 16'd0) begin
              w_state_nxt = S_ARMED;
            end else begin
              w_state_nxt = S_HOLDOFF;
              w_hcnt_nxt  = bus.ctl_holdoff;
            end
          end
        end
        S_HOLDOFF: begin
          w_hcnt_nxt = r_hcnt - 16'd1;
          if (r_hcnt == 16'd1) w_state_nxt = S_ARMED;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // FSM state, holdoff counter and the first-SOF-after-arming flag.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state <= S_IDLE;
      r_hcnt  <= 16'd0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      if ((r_state == S_IDLE) && (w_state_nxt == S_ARMED)) begin
        r_first <= 1'b1;
      end else if (w_fire) begin
        r_first <= 1'b0;
      end
    end
  end

  // Free-running timestamp, wraps naturally.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Run length of consecutive zero words, saturating at PRE_ZERO.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_zero_run <= 8'd0;
    end else if (!bus.ctl_en || (w_data != '0)) begin
      r_zero_run <= 8'd0;
    end else if (r_zero_run != PZ) begin
      r_zero_run <= r_zero_run + 8'd1;
    end
  end

  // ---- stage p1: fire outputs, one cycle after the triggering word ----
  // Capture registers; bitpos and ts hold their value between fires.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_vld_p1    <= 1'b0;
      r_run_p1    <= 1'b0;
      r_bitpos_p1 <= '0;
      r_ts_p1     <= '0;
    end else begin
      r_vld_p1 <= w_fire;
      r_run_p1 <= w_fire && r_first;
      if (w_fire) begin
        r_bitpos_p1 <= w_bitpos;
        r_ts_p1     <= r_ts;
      end
    end
  end

  // SOF event counter; a clear beats a coincident fire.
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_cnt <= '0;
    end else if (bus.ctl_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_fire) begin
      r_cnt <= f_sat_inc(r_cnt);
    end
  end

  assign bus.rx_sof                = r_vld_p1;
  assign bus.rx_sof_bitpos         = r_bitpos_p1;
  assign bus.rx_sof_ts             = r_ts_p1;
  assign bus.rx_start_measured_run = r_run_p1;
  assign bus.stat_sof_cnt          = r_cnt;
  assign bus.stat_state            = r_state;
endmodule
